// File: rtl/ccip_c1_wr_arbiter.sv
// ccip_c1_wr_arbiter
//
// Shares the CCI-P c1 (memory write) transmit channel among N_REQ write
// requesters. Grants are round-robin, or fixed priority when the
// C1_ARB_FIXED_PRIO_EN macro is defined. A grant is withheld when c1TxAlmFull
// is high or when MAX_OUTSTANDING writes are in flight. Write responses are
// routed back to the requester by the mdata tag. A flush drains every
// in-flight write before flush_done pulses.
//
// Ports:
//   pClk, pck_cp2af_softReset_n  clock, asynchronous active-low reset
//   req_valid/req_addr/req_data  per-requester write request (42b addr, 512b data)
//   req_ready                    one-hot grant (combinational)
//   wr_done                      per-requester completion pulse
//   flush_req / flush_done       drain request (level) / completion pulse
//   c1TxAlmFull                  c1 back-pressure
//   c1Tx_hdr/c1Tx_data/c1Tx_valid registered c1 write request
//   c1Rx_hdr/c1Rx_rspValid       c1 write response
//   outstanding                  in-flight write count
module ccip_c1_wr_arbiter #(
    parameter int N_REQ               = 4,
    parameter int MAX_OUTSTANDING     = 64,
    parameter int ID_W                = $clog2(N_REQ),
    parameter int CCIP_C1TX_HDR_WIDTH = 80,
    parameter int CCIP_C1RX_HDR_WIDTH = 28,
    localparam int CNT_W              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           pClk,
    input  logic                           pck_cp2af_softReset_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*42-1:0]            req_addr,
    input  logic [N_REQ*512-1:0]           req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_REQ-1:0]               wr_done,
    input  logic                           flush_req,
    output logic                           flush_done,
    input  logic                           c1TxAlmFull,
    output logic [CCIP_C1TX_HDR_WIDTH-1:0] c1Tx_hdr,
    output logic [511:0]                   c1Tx_data,
    output logic                           c1Tx_valid,
    input  logic [CCIP_C1RX_HDR_WIDTH-1:0] c1Rx_hdr,
    input  logic                           c1Rx_rspValid,
    output logic [CNT_W-1:0]               outstanding
);

    // t_ccip_c1_ReqMemHdr encodings: eVC_VA, eCL_LEN_1, eREQ_WRLINE_I
    localparam logic [1:0] VC_VA        = 2'b00;
    localparam logic [1:0] CL_LEN_1     = 2'b00;
    localparam logic [3:0] REQ_WRLINE_I = 4'h0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                           state_r, state_nxt_s;
    logic [CNT_W-1:0]                 cnt_r;
    logic [ID_W-1:0]                  sel_s;
    logic                             grant_ok_s;
    logic                             rsp_eff_s;
    logic                             drain_ok_s;
    logic                             flush_done_nxt_s;
    logic [N_REQ-1:0]                 wr_done_r;
    logic                             flush_done_r;
    logic                             c1tx_valid_r;
    logic [CCIP_C1TX_HDR_WIDTH-1:0]   c1tx_hdr_r;
    logic [511:0]                     c1tx_data_r;
    logic                             unused_s;

    // Id to one-hot; ids at or above N_REQ map to all zeros.
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            oh[k] = (int'(id) == k);
        end
        return oh;
    endfunction

    // Build a single-line WrLine_I header; mdata carries only the requester id.
    function automatic logic [CCIP_C1TX_HDR_WIDTH-1:0] mk_hdr(input logic [41:0] addr,
                                                             input logic [ID_W-1:0] id);
        logic [CCIP_C1TX_HDR_WIDTH-1:0] h;
        h          = '0;
        h[15:0]    = {{(16-ID_W){1'b0}}, id};
        h[57:16]   = addr;
        h[67:64]   = REQ_WRLINE_I;
        h[69:68]   = CL_LEN_1;
        h[71]      = 1'b1;
        h[73:72]   = VC_VA;
        return h;
    endfunction

    // Only the id bits of the response mdata matter here.
    assign unused_s = ^c1Rx_hdr[CCIP_C1RX_HDR_WIDTH-1:ID_W];

`ifdef C1_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest valid index wins.
    always_comb begin
        sel_s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sel_s = req_valid[k] ? ID_W'(k) : sel_s;
        end
    end
`else
    logic [ID_W-1:0] last_grant_r;
    logic            found_s;

    // Round-robin: first valid requester after the last granted one.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found_s && req_valid[(int'(last_grant_r) + 1 + k) % N_REQ]) begin
                sel_s   = ID_W'((int'(last_grant_r) + 1 + k) % N_REQ);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Last-grant pointer moves only on a transfer; reset makes requester 0 first.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            last_grant_r <= ID_W'(N_REQ - 1);
        end else if (grant_ok_s) begin
            last_grant_r <= sel_s;
        end
    end
`endif

    // Grant only when running, not back-pressured and below the in-flight cap.
    assign grant_ok_s = (state_r == ST_RUN) && !c1TxAlmFull &&
                        (cnt_r < CNT_W'(MAX_OUTSTANDING)) && (|req_valid);
    assign req_ready  = grant_ok_s ? id_to_onehot(sel_s) : '0;

    // A response with nothing in flight is stray and must not underflow.
    assign rsp_eff_s  = c1Rx_rspValid && (cnt_r != '0);
    assign drain_ok_s = (cnt_r == '0) && !(|req_ready) && !c1tx_valid_r;

    // FSM next state and drain-complete strobe.
    always_comb begin
        state_nxt_s      = state_r;
        flush_done_nxt_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (flush_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_ok_s) begin
                    state_nxt_s      = ST_DONE;
                    flush_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register and flush_done pulse.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            state_r      <= ST_RUN;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            flush_done_r <= flush_done_nxt_s;
        end
    end

    // In-flight counter; simultaneous issue and response cancel out.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            cnt_r <= '0;
        end else begin
            case ({grant_ok_s, rsp_eff_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // c1 output register loads the granted request for a single-cycle valid.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            c1tx_valid_r <= 1'b0;
            c1tx_hdr_r   <= '0;
            c1tx_data_r  <= '0;
        end else begin
            c1tx_valid_r <= grant_ok_s;
            if (grant_ok_s) begin
                c1tx_hdr_r  <= mk_hdr(req_addr[int'(sel_s)*42 +: 42], sel_s);
                c1tx_data_r <= req_data[int'(sel_s)*512 +: 512];
            end
        end
    end

    // Route each response back to its requester by mdata tag.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            wr_done_r <= '0;
        end else if (c1Rx_rspValid) begin
            wr_done_r <= id_to_onehot(c1Rx_hdr[ID_W-1:0]);
        end else begin
            wr_done_r <= '0;
        end
    end

    assign wr_done     = wr_done_r;
    assign flush_done  = flush_done_r;
    assign c1Tx_valid  = c1tx_valid_r;
    assign c1Tx_hdr    = c1tx_hdr_r;
    assign c1Tx_data   = c1tx_data_r;
    assign outstanding = cnt_r;

endmodule

// File: tb/tb_ccip_c1_wr_arbiter.sv
module tb_ccip_c1_wr_arbiter;

    localparam int N   = 4;
    localparam int MAX = 8;

    logic              pClk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*42-1:0]   req_addr;
    logic [N*512-1:0]  req_data;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      wr_done;
    logic              flush_req = 1'b0;
    logic              flush_done;
    logic              c1TxAlmFull = 1'b0;
    logic [79:0]       c1Tx_hdr;
    logic [511:0]      c1Tx_data;
    logic              c1Tx_valid;
    logic [27:0]       c1Rx_hdr = '0;
    logic              c1Rx_rspValid = 1'b0;
    logic [3:0]        outstanding;

    int checks = 0;
    int failures = 0;

    ccip_c1_wr_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
        .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_done(wr_done),
        .flush_req(flush_req), .flush_done(flush_done),
        .c1TxAlmFull(c1TxAlmFull),
        .c1Tx_hdr(c1Tx_hdr), .c1Tx_data(c1Tx_data), .c1Tx_valid(c1Tx_valid),
        .c1Rx_hdr(c1Rx_hdr), .c1Rx_rspValid(c1Rx_rspValid),
        .outstanding(outstanding)
    );

    always #5 pClk = ~pClk;

    function automatic logic [41:0] addr_of(input int id);
        return 42'h0_1234_5670 + 42'(id);
    endfunction

    function automatic logic [511:0] data_of(input int id);
        return {16{32'hC0DE_0000 + 32'(id)}};
    endfunction

    // Expected WrLine_I header: vc=VA, sop=1, cl_len=1 line, mdata=id.
    function automatic logic [79:0] exp_hdr(input int id);
        return {6'b0, 2'b00, 1'b1, 1'b0, 2'b00, 4'h0, 6'b0, addr_of(id), 16'(id)};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then wait to the sample point.
    task automatic cyc(input logic [3:0] rv, input logic alm, input logic rsp,
                       input logic [1:0] rid, input logic fl);
        @(posedge pClk);
        #1;
        req_valid     = rv;
        c1TxAlmFull   = alm;
        c1Rx_rspValid = rsp;
        c1Rx_hdr      = 28'(rid);
        flush_req     = fl;
        @(negedge pClk);
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       alm;
        logic       rsp;
        logic [1:0] rid;
        logic [3:0] e_ready;
        logic       e_txv;
        logic [1:0] e_md;
        logic [3:0] e_wd;
        logic [3:0] e_out;
    } vec_t;

    vec_t vecs[30];

    initial begin
        bit seen;
        for (int i = 0; i < N; i++) begin
            req_addr[i*42 +: 42]   = addr_of(i);
            req_data[i*512 +: 512] = data_of(i);
        end

        // rv, alm, rsp, rid | ready, txv, mdata, wr_done, outstanding
        vecs[0]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 4'b0000, 4'd0};
        vecs[1]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd0, 4'b0000, 4'd1};
        vecs[2]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd1, 4'b0000, 4'd2};
        vecs[3]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd2, 4'b0000, 4'd3};
        vecs[4]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd3, 4'b0000, 4'd4};
        vecs[5]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd0, 4'b0000, 4'd5};
        vecs[6]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd1, 4'b0000, 4'd6};
        vecs[7]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd2, 4'b0000, 4'd7};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 4'b0000, 4'd8};
        vecs[9]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd8};
        vecs[10] = '{4'b1111, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd8};
        vecs[11] = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 4'b0100, 4'd7};
        vecs[12] = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 4'b0000, 4'd8};
        vecs[13] = '{4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd8};
        vecs[14] = '{4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0, 4'b0010, 4'd7};
        vecs[15] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b1000, 4'd6};
        vecs[16] = '{4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 4'b0001, 4'd5};
        vecs[17] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 4'b0010, 4'd4};
        vecs[18] = '{4'b0010, 1'b0, 1'b1, 2'd2, 4'b0010, 1'b0, 2'd0, 4'b0100, 4'd3};
        vecs[19] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 4'b0100, 4'd3};
        vecs[20] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd3};
        vecs[21] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd3};
        vecs[22] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd3};
        vecs[23] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd3};
        vecs[24] = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd0, 4'b0000, 4'd3};
        vecs[25] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 4'b0000, 4'd4};
        vecs[26] = '{4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b0, 2'd0, 4'b0000, 4'd4};
        vecs[27] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 4'b0000, 4'd5};
        vecs[28] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd5};
        vecs[29] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'd5};

        // Reset values
        repeat (2) @(posedge pClk);
        @(negedge pClk);
        chk("rst_ready", 512'(req_ready), 512'(4'b0000));
        chk("rst_wr_done", 512'(wr_done), 512'(4'b0000));
        chk("rst_flush_done", 512'(flush_done), 512'(1'b0));
        chk("rst_tx_valid", 512'(c1Tx_valid), 512'(1'b0));
        chk("rst_tx_hdr", 512'(c1Tx_hdr), 512'(80'h0));
        chk("rst_tx_data", c1Tx_data, 512'h0);
        chk("rst_outstanding", 512'(outstanding), 512'(4'd0));
        rst_n = 1'b1;

        // Table: round robin, in-flight cap, same-cycle issue/response, almost-full
        for (int i = 0; i < 30; i++) begin
            cyc(vecs[i].rv, vecs[i].alm, vecs[i].rsp, vecs[i].rid, 1'b0);
            chk($sformatf("v%0d_ready", i), 512'(req_ready), 512'(vecs[i].e_ready));
            chk($sformatf("v%0d_txv", i), 512'(c1Tx_valid), 512'(vecs[i].e_txv));
            chk($sformatf("v%0d_wr_done", i), 512'(wr_done), 512'(vecs[i].e_wd));
            chk($sformatf("v%0d_out", i), 512'(outstanding), 512'(vecs[i].e_out));
            if (vecs[i].e_txv) begin
                chk($sformatf("v%0d_hdr", i), 512'(c1Tx_hdr), 512'(exp_hdr(int'(vecs[i].e_md))));
                chk($sformatf("v%0d_data", i), c1Tx_data, data_of(int'(vecs[i].e_md)));
            end
        end

        // Flush with 5 in flight; flush_req drops during the drain
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        cyc(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("drain_no_grant", 512'(req_ready), 512'(4'b0000));
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 1'b0, 1'b1, 2'(k % 4), 1'b0);
            chk($sformatf("drain%0d_no_grant", k), 512'(req_ready), 512'(4'b0000));
            chk($sformatf("drain%0d_no_done", k), 512'(flush_done), 512'(1'b0));
            chk($sformatf("drain%0d_out", k), 512'(outstanding), 512'(4'd5 - 4'(k)));
        end
        cyc(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("drain_last_wr_done", 512'(wr_done), 512'(4'b0001));
        chk("drain_out_zero", 512'(outstanding), 512'(4'd0));
        chk("drain_done_not_yet", 512'(flush_done), 512'(1'b0));
        cyc(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("flush_done_pulse", 512'(flush_done), 512'(1'b1));
        chk("done_no_grant", 512'(req_ready), 512'(4'b0000));
        cyc(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("flush_done_single", 512'(flush_done), 512'(1'b0));
        chk("run_resumes", 512'(req_ready), 512'(4'b0001));

        // Build 7 in flight, then reset mid-operation
        for (int k = 0; k < 6; k++) begin
            cyc(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        end
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("pre_reset_out", 512'(outstanding), 512'(4'd7));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 512'(outstanding), 512'(4'd0));
        chk("async_rst_txv", 512'(c1Tx_valid), 512'(1'b0));
        chk("async_rst_hdr", 512'(c1Tx_hdr), 512'(80'h0));
        @(negedge pClk);
        rst_n = 1'b1;

        // Stray responses after reset: counter clamps, tags still route
        for (int k = 0; k < 7; k++) begin
            cyc(4'b0000, 1'b0, 1'b1, 2'(k % 4), 1'b0);
            chk($sformatf("stray%0d_out", k), 512'(outstanding), 512'(4'd0));
            chk($sformatf("stray%0d_wr_done", k), 512'(wr_done),
                512'((k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4))));
        end
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("stray_last_wr_done", 512'(wr_done), 512'(4'b0100));
        chk("stray_final_out", 512'(outstanding), 512'(4'd0));

        // Flush after stray responses must complete within a bounded time
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
            seen = flush_done;
        end
        chk("post_reset_flush_done", 512'(seen), 512'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccip_c1_wr_arbiter.md
# ccip_c1_wr_arbiter

Shares the single CCI-P c1 (memory write) transmit channel among N_REQ on-chip write requesters. It sits between the AFU's write engines and the flat c1Tx/c1Rx signals of ccip_std_afu_wrapper. It applies round-robin arbitration and honours c1TxAlmFull. It bounds outstanding writes to MAX_OUTSTANDING, routes write responses back to the issuing requester by mdata tag, and provides a drain/flush sequence so software never reuses a buffer while writes to it are still in flight.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..16.
- MAX_OUTSTANDING, 64: maximum issued-but-unacknowledged writes, 1..255.
- ID_W, $clog2(N_REQ): width of the requester-id tag in mdata.

Ports:
- pClk, in, 1: clock, the only clock.
- pck_cp2af_softReset_n, in, 1: reset, asynchronous, active-low.
- req_valid, in, N_REQ: requester i has a write pending.
- req_addr, in, N_REQ*42: cache-line address, requester i in bits [42i+41:42i].
- req_data, in, N_REQ*512: line data, requester i in bits [512i+511:512i].
- req_ready, out, N_REQ: one-hot grant; transfer on req_valid[i] & req_ready[i].
- wr_done, out, N_REQ: one-cycle pulse when requester i's write is acknowledged.
- flush_req, in, 1: level; requests drain of all outstanding writes.
- flush_done, out, 1: one-cycle pulse when the drain completes.
- c1TxAlmFull, in, 1: c1 transmit almost-full.
- c1Tx_hdr, out, CCIP_C1TX_HDR_WIDTH: packed t_ccip_c1_ReqMemHdr.
- c1Tx_data, out, 512: write data.
- c1Tx_valid, out, 1: write request valid.
- c1Rx_hdr, in, CCIP_C1RX_HDR_WIDTH: packed response header.
- c1Rx_rspValid, in, 1: write response valid.
- outstanding, out, $clog2(MAX_OUTSTANDING+1): current in-flight count.

## Operation
- State machine RUN / DRAIN / DONE; reset state is RUN.
  - RUN to DRAIN when flush_req=1.
  - DRAIN to DONE when outstanding==0, no grant is pending and c1Tx_valid=0.
  - DONE to RUN unconditionally after one cycle.
- Grant eligibility requires all of: state RUN, c1TxAlmFull=0, outstanding<MAX_OUTSTANDING, and at least one req_valid. Otherwise req_ready=0.
- Round-robin selection:
  - The search starts at (last_grant+1) mod N_REQ; the first set req_valid wins.
  - last_grant updates only on a transfer and resets to N_REQ-1, so requester 0 has first priority.
- Issue: on a transfer the output register loads the request.
  - Header fields: vc_sel=eVC_VA, sop=1, cl_len=eCL_LEN_1, req_type=eREQ_WRLINE_I, address=req_addr[i].
  - mdata[ID_W-1:0]=i; all other mdata bits are 0.
  - c1Tx_data=req_data[i]; c1Tx_valid=1 for exactly one cycle.
- Counter:
  - Increments on a transfer and decrements on c1Rx_rspValid.
  - If both occur in one cycle, it is unchanged.
  - It never exceeds MAX_OUTSTANDING. A response arriving at outstanding==0 is ignored and the counter holds at 0 (no underflow).
- Response routing: on c1Rx_rspValid, wr_done[c1Rx_hdr.mdata[ID_W-1:0]] pulses on the next cycle. An id >= N_REQ produces no pulse but still decrements the counter.
- flush_req that deasserts during DRAIN does not abort the drain. flush_req still high in RUN after DONE starts another drain.
- Reset mid-operation: all state clears immediately. In-flight responses arriving after reset release are counted as stray and clamp at 0.

## Timing
- req_ready is combinational from req_valid, state, c1TxAlmFull, outstanding and last_grant. There is no combinational path from req_ready back into any requester input.
- Transfer at cycle t gives c1Tx_valid at t+1.
- c1Rx_rspValid at t gives wr_done at t+1 and outstanding updated at t+1.
- c1TxAlmFull sampled at t blocks a grant at t, so at most 1 further request follows its assertion.
- flush_done rises at the earliest 1 cycle after the drain condition is met.
- Reset values:
  - req_ready=0, wr_done=0, flush_done=0.
  - c1Tx_valid=0, c1Tx_hdr=0, c1Tx_data=0.
  - outstanding=0, state=RUN.

## Configuration
- C1_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest index wins, and last_grant is unused.
  - Undefined (default): round-robin as described under Operation.
- All other behaviour is identical in both builds.

## Test plan
- All 4 requesters hold req_valid=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; c1Tx mdata 0,1,2,3,... one cycle after each grant.
- MAX_OUTSTANDING=4 with no responses and constant requests -> exactly 4 issues, req_ready=0 thereafter. One response -> exactly one more issue.
- c1TxAlmFull=1 for 10 cycles with requests pending -> no c1Tx_valid during cycles 2..10; issue resumes the cycle after c1TxAlmFull deasserts.
- Transfer and c1Rx_rspValid in the same cycle at outstanding=3 -> outstanding stays 3. Response mdata=2 -> wr_done=4'b0100 for one cycle.
- flush_req with 5 outstanding -> no grants. flush_done pulses one cycle after the 5th response and state returns to RUN.
- Reset asserted with 7 outstanding, then 7 responses after release -> outstanding stays 0, no flush hang, wr_done pulses per tag.
